// File: rtl/core_mem_pkg.sv
// Shared types for the memory port arbiter: access widths, response owners and the
// in-flight tracking record, plus the alignment rule used for every request.
package core_mem_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // store marks an access whose response is a bare acknowledgement (data forced to 0)
    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   err;
        logic   store;
    } inflight_t;

    function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] addr_lo);
        logic ok;
        case (width)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~addr_lo[0];
            WORD:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_rsp_tracker.sv
// Fixed-latency shift pipeline of in-flight accesses; the head is the response due this
// cycle. A fetch flush drops every in-flight fetch entry but keeps the one being pushed.
module mem_rsp_tracker
    import core_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  inflight_t push_entry,
    input  logic      flush_if,
    output inflight_t head
);

    inflight_t [DEPTH-1:0] stage_q;
    inflight_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = '0;
        stage_d[0] = push_entry;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
            if (flush_if && stage_q[i-1].owner == OWN_IF) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // The entry presented this cycle is also suppressed by a flush
    always_comb begin
        head = stage_q[DEPTH-1];
        if (flush_if && head.owner == OWN_IF) begin
            head.valid = 1'b0;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, issuing at most
// one access per cycle and routing each fixed-latency response back to its requester.
module memory_port_arbiter
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_STARVE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    input  logic                  if_flush,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    output logic                  if_rsp_err,
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic                  ls_req_we,
    input  logic [1:0]            ls_req_width,
    input  logic [ADDR_WIDTH-1:0] ls_req_addr,
    input  logic [DATA_WIDTH-1:0] ls_req_wdata,
    output logic                  ls_rsp_valid,
    output logic [DATA_WIDTH-1:0] ls_rsp_data,
    output logic                  ls_rsp_err,
    output logic                  mem_we,
    output logic [1:0]            mem_data_width,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                if_grant, ls_grant;
    logic                if_aligned, ls_aligned;
    inflight_t           push_entry, head;

    // Load/store has priority until a pending fetch has been denied MAX_STARVE times
    always_comb begin
        if_grant = 1'b0;
        ls_grant = 1'b0;
        if (!rst) begin
            if_grant = if_req_valid &&
                       (!ls_req_valid || starve_cnt_q == STARVE_W'(MAX_STARVE));
            ls_grant = ls_req_valid && !if_grant;
        end
    end

    assign if_req_ready = if_grant;
    assign ls_req_ready = ls_grant;
    assign if_aligned   = is_aligned(WORD, if_req_addr[1:0]);
    assign ls_aligned   = is_aligned(ls_req_width, ls_req_addr[1:0]);

    always_comb begin
        if (!if_req_valid || if_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_W'(MAX_STARVE)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_data_width = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        push_entry     = '0;
        if (if_grant) begin
            mem_data_width   = WORD;
            mem_addr         = if_req_addr;
            push_entry.valid = 1'b1;
            push_entry.owner = OWN_IF;
            push_entry.err   = ~if_aligned;
        end else if (ls_grant) begin
            mem_we           = ls_req_we && ls_aligned;
            mem_data_width   = ls_req_width;
            mem_addr         = ls_req_addr;
            mem_write_data   = ls_req_wdata;
            push_entry.valid = 1'b1;
            push_entry.owner = OWN_LS;
            push_entry.err   = ~ls_aligned;
            push_entry.store = ls_req_we;
        end
    end

    mem_rsp_tracker #(
        .DEPTH(READ_LATENCY)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .push_entry(push_entry),
        .flush_if  (if_flush),
        .head      (head)
    );

    always_comb begin
        if_rsp_valid = !rst && head.valid && head.owner == OWN_IF;
        ls_rsp_valid = !rst && head.valid && head.owner == OWN_LS;
        if_rsp_err   = if_rsp_valid && head.err;
        ls_rsp_err   = ls_rsp_valid && head.err;
        if_rsp_data  = (if_rsp_valid && !head.err) ? mem_read_data : '0;
        ls_rsp_data  = (ls_rsp_valid && !head.err && !head.store) ? mem_read_data : '0;
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: a behavioural memory, a per-cycle reference model of
// grants and responses, a vector table, directed corner sequences and random traffic.
module tb_memory_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_flush;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid, if_rsp_err;
    logic [31:0] if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_req_we;
    logic [1:0]  ls_req_width;
    logic [31:0] ls_req_addr, ls_req_wdata;
    logic        ls_rsp_valid, ls_rsp_err;
    logic [31:0] ls_rsp_data;
    logic        mem_we;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    memory_port_arbiter #(
        .ADDR_WIDTH  (32),
        .READ_LATENCY(2),
        .MAX_STARVE  (MAXS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_flush      (if_flush),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .if_rsp_err    (if_rsp_err),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_req_we     (ls_req_we),
        .ls_req_width  (ls_req_width),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rsp_data   (ls_rsp_data),
        .ls_rsp_err    (ls_rsp_err),
        .mem_we        (mem_we),
        .mem_data_width(mem_data_width),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Behavioural single-port memory: 64 bytes, read data valid two cycles after the edge
    logic [31:0] env_mem [16];
    bit          env_init = 1'b0;
    logic [31:0] rd0 = '0;
    logic [31:0] rd1 = '0;
    assign mem_read_data = rd1;

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
            env_init <= 1'b1;
        end else if (mem_we) begin
            case (mem_data_width)
                2'b00: env_mem[mem_addr[5:2]][8*mem_addr[1:0] +: 8] <= mem_write_data[7:0];
                2'b01: env_mem[mem_addr[5:2]][16*mem_addr[1] +: 16] <= mem_write_data[15:0];
                default: env_mem[mem_addr[5:2]] <= mem_write_data;
            endcase
        end
        rd0 <= env_mem[mem_addr[5:2]];
        rd1 <= rd0;
    end

    // Reference model: byte-addressed shadow memory plus responses due per cycle
    typedef struct {
        bit          v;
        bit          e;
        logic [31:0] d;
    } rsp_t;

    logic [7:0] ref_mem [64];
    rsp_t       exp_if [4];
    rsp_t       exp_ls [4];
    int         cyc    = 0;
    int         starve = 0;
    int         n_vec  = 0;
    int         n_err  = 0;

    bit          d_rst, d_if_v, d_flush, d_ls_v, d_ls_we;
    logic [1:0]  d_ls_w;
    logic [31:0] d_if_a, d_ls_a, d_ls_wd;

    function automatic bit aligned(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 1'b0;
        return (a % (32'd1 << w)) == 0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = 4 * int'(a[5:2]);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < (1 << w); k++) ref_mem[int'(a[5:0]) + k] = d[8*k +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then check every output against the model
    task automatic step();
        bit          e_if_rdy, e_ls_rdy, e_we, err;
        logic [1:0]  e_w;
        logic [31:0] e_a, e_wd;
        int          s, n;
        @(negedge clk);
        rst          = d_rst;
        if_req_valid = d_if_v;
        if_req_addr  = d_if_a;
        if_flush     = d_flush;
        ls_req_valid = d_ls_v;
        ls_req_we    = d_ls_we;
        ls_req_width = d_ls_w;
        ls_req_addr  = d_ls_a;
        ls_req_wdata = d_ls_wd;
        #1;
        s = cyc % 4;
        n = (cyc + 2) % 4;
        if (d_rst) begin
            e_if_rdy = 1'b0;
            e_ls_rdy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                exp_if[i].v = 1'b0;
                exp_ls[i].v = 1'b0;
            end
        end else begin
            e_if_rdy = d_if_v && (!d_ls_v || starve == MAXS);
            e_ls_rdy = d_ls_v && !e_if_rdy;
            if (d_flush) begin
                exp_if[s].v = 1'b0;
                exp_if[(cyc + 1) % 4].v = 1'b0;
            end
        end
        e_we = 1'b0;
        e_w  = 2'b00;
        e_a  = '0;
        e_wd = '0;
        if (e_if_rdy) begin
            e_w = 2'b10;
            e_a = d_if_a;
        end else if (e_ls_rdy) begin
            e_w  = d_ls_w;
            e_a  = d_ls_a;
            e_wd = d_ls_wd;
            e_we = d_ls_we && aligned(d_ls_w, d_ls_a);
        end
        check("if_req_ready", 32'(if_req_ready), 32'(e_if_rdy));
        check("ls_req_ready", 32'(ls_req_ready), 32'(e_ls_rdy));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_data_width", 32'(mem_data_width), 32'(e_w));
        check("mem_addr", mem_addr, e_a);
        check("mem_write_data", mem_write_data, e_wd);
        check("if_rsp_valid", 32'(if_rsp_valid), 32'(exp_if[s].v));
        check("if_rsp_err", 32'(if_rsp_err), 32'(exp_if[s].v && exp_if[s].e));
        if (exp_if[s].v) check("if_rsp_data", if_rsp_data, exp_if[s].d);
        check("ls_rsp_valid", 32'(ls_rsp_valid), 32'(exp_ls[s].v));
        check("ls_rsp_err", 32'(ls_rsp_err), 32'(exp_ls[s].v && exp_ls[s].e));
        if (exp_ls[s].v) check("ls_rsp_data", ls_rsp_data, exp_ls[s].d);
        exp_if[s].v = 1'b0;
        exp_ls[s].v = 1'b0;
        if (e_if_rdy) begin
            err = (d_if_a[1:0] != 2'b00);
            exp_if[n] = '{v: 1'b1, e: err, d: err ? 32'h0 : ref_word(d_if_a)};
        end
        if (e_ls_rdy) begin
            err = !aligned(d_ls_w, d_ls_a);
            exp_ls[n] = '{v: 1'b1, e: err, d: (err || d_ls_we) ? 32'h0 : ref_word(d_ls_a)};
            if (!err && d_ls_we) ref_store(d_ls_w, d_ls_a, d_ls_wd);
        end
        if (d_rst || !d_if_v || e_if_rdy) starve = 0;
        else if (starve < MAXS) starve++;
        cyc++;
    endtask

    task automatic clear_drive();
        d_rst   = 1'b0;
        d_if_v  = 1'b0;
        d_flush = 1'b0;
        d_ls_v  = 1'b0;
        d_ls_we = 1'b0;
        d_ls_w  = 2'b00;
        d_if_a  = '0;
        d_ls_a  = '0;
        d_ls_wd = '0;
    endtask

    task automatic idle();
        clear_drive();
        step();
    endtask

    task automatic ls_op(input bit we, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd);
        clear_drive();
        d_ls_v  = 1'b1;
        d_ls_we = we;
        d_ls_w  = w;
        d_ls_a  = a;
        d_ls_wd = wd;
        step();
    endtask

    task automatic fetch(input logic [31:0] a, input bit flush);
        clear_drive();
        d_if_v  = 1'b1;
        d_if_a  = a;
        d_flush = flush;
        step();
    endtask

    typedef struct {
        bit          if_v;
        bit          ls_v;
        bit          we;
        logic [1:0]  w;
        logic [31:0] ls_a;
        logic [31:0] ls_wd;
        logic [31:0] if_a;
        bit          x_if;
        bit          x_ls;
        bit          x_we;
        logic [1:0]  x_w;
        logic [31:0] x_a;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        bit          grant_if;
        for (int i = 0; i < 16; i++) begin
            w = init_word(i);
            for (int k = 0; k < 4; k++) ref_mem[4*i + k] = w[8*k +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            exp_if[i] = '{v: 1'b0, e: 1'b0, d: 32'h0};
            exp_ls[i] = '{v: 1'b0, e: 1'b0, d: 32'h0};
        end
        rst = 1'b1; if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_width = '0;
        ls_req_addr = '0; ls_req_wdata = '0;

        // {if_v, ls_v, we, width, ls_addr, wdata, if_addr, if_rdy, ls_rdy, mem_we, width, addr}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0,  32'h0,        32'd8,  1'b1, 1'b0, 1'b0, 2'd2, 32'd8};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'd12, 32'h0,        32'd0,  1'b0, 1'b1, 1'b0, 2'd2, 32'd12};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 2'd0, 32'd5,  32'h5A,       32'd8,  1'b0, 1'b1, 1'b1, 2'd0, 32'd5};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'd6,  32'h1234,     32'd0,  1'b0, 1'b1, 1'b1, 2'd1, 32'd6};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'd7,  32'hDEAD,     32'd0,  1'b0, 1'b1, 1'b0, 2'd1, 32'd7};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'd8,  32'hBEEF,     32'd0,  1'b0, 1'b1, 1'b0, 2'd3, 32'd8};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'd16, 32'hCAFEF00D, 32'd0,  1'b0, 1'b1, 1'b1, 2'd2, 32'd16};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0,  32'h0,        32'd0,  1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'd18, 32'h55,       32'd0,  1'b0, 1'b1, 1'b0, 2'd2, 32'd18};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'd3,  32'h0,        32'd20, 1'b0, 1'b1, 1'b0, 2'd0, 32'd3};

        // Reset with both requesters asking: nothing may be granted or driven
        clear_drive();
        d_rst  = 1'b1;
        d_if_v = 1'b1;
        d_ls_v = 1'b1;
        step();
        step();
        check("reset if_req_ready", 32'(if_req_ready), 32'd0);
        check("reset ls_req_ready", 32'(ls_req_ready), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        idle();

        foreach (tbl[i]) begin
            clear_drive();
            d_if_v  = tbl[i].if_v;
            d_ls_v  = tbl[i].ls_v;
            d_ls_we = tbl[i].we;
            d_ls_w  = tbl[i].w;
            d_ls_a  = tbl[i].ls_a;
            d_ls_wd = tbl[i].ls_wd;
            d_if_a  = tbl[i].if_a;
            step();
            check($sformatf("tbl%0d if_req_ready", i), 32'(if_req_ready), 32'(tbl[i].x_if));
            check($sformatf("tbl%0d ls_req_ready", i), 32'(ls_req_ready), 32'(tbl[i].x_ls));
            check($sformatf("tbl%0d mem_we", i), 32'(mem_we), 32'(tbl[i].x_we));
            check($sformatf("tbl%0d mem_data_width", i), 32'(mem_data_width), 32'(tbl[i].x_w));
            check($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].x_a);
            idle();
        end
        idle();

        // Word store then lone fetch of the same word
        ls_op(1'b1, 2'd2, 32'h0, 32'h77FF99AA);
        fetch(32'h0, 1'b0);
        check("lone fetch ready", 32'(if_req_ready), 32'd1);
        idle();
        idle();
        check("lone fetch rsp_valid", 32'(if_rsp_valid), 32'd1);
        check("lone fetch rsp_data", if_rsp_data, 32'h77FF99AA);

        // Contention: load/store wins four times, then the starved fetch wins
        idle();
        for (int k = 0; k < 8; k++) begin
            clear_drive();
            d_if_v = 1'b1;
            d_if_a = 32'd4;
            d_ls_v = 1'b1;
            d_ls_w = 2'd2;
            d_ls_a = 32'd8;
            step();
            grant_if = (k == 4);
            check($sformatf("contend%0d if_req_ready", k), 32'(if_req_ready), 32'(grant_if));
            check($sformatf("contend%0d ls_req_ready", k), 32'(ls_req_ready), 32'(!grant_if));
        end
        idle();
        idle();

        // Misaligned accesses report an error and leave memory untouched
        ls_op(1'b0, 2'd2, 32'h2, 32'h0);
        idle();
        idle();
        check("misaligned load rsp_err", 32'(ls_rsp_err), 32'd1);
        check("misaligned load rsp_data", ls_rsp_data, 32'd0);
        ls_op(1'b1, 2'd1, 32'h1, 32'h11111111);
        check("misaligned store mem_we", 32'(mem_we), 32'd0);
        idle();
        idle();
        check("misaligned store rsp_err", 32'(ls_rsp_err), 32'd1);
        ls_op(1'b0, 2'd2, 32'h0, 32'h0);
        idle();
        idle();
        check("unchanged word", ls_rsp_data, 32'h77FF99AA);

        // Byte store acknowledged, then the following load sees the new top byte
        ls_op(1'b1, 2'd0, 32'h3, 32'hAB);
        ls_op(1'b0, 2'd2, 32'h0, 32'h0);
        idle();
        check("store ack valid", 32'(ls_rsp_valid), 32'd1);
        check("store ack err", 32'(ls_rsp_err), 32'd0);
        check("store ack data", ls_rsp_data, 32'd0);
        idle();
        check("load after byte store", ls_rsp_data, 32'hABFF99AA);

        // Flush drops the older fetch but keeps the one accepted with it
        fetch(32'h0, 1'b0);
        fetch(32'h8, 1'b1);
        check("flush-cycle fetch ready", 32'(if_req_ready), 32'd1);
        idle();
        check("flushed fetch dropped", 32'(if_rsp_valid), 32'd0);
        idle();
        check("post-flush fetch valid", 32'(if_rsp_valid), 32'd1);
        check("post-flush fetch data", if_rsp_data, 32'hC0DE0002);

        // Reset with two reads in flight
        ls_op(1'b0, 2'd2, 32'h0, 32'h0);
        ls_op(1'b0, 2'd2, 32'h8, 32'h0);
        clear_drive();
        d_rst  = 1'b1;
        d_if_v = 1'b1;
        d_ls_v = 1'b1;
        step();
        check("mid-reset if_req_ready", 32'(if_req_ready), 32'd0);
        check("mid-reset ls_req_ready", 32'(ls_req_ready), 32'd0);
        check("mid-reset ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            idle();
            check($sformatf("post-reset%0d ls_rsp_valid", k), 32'(ls_rsp_valid), 32'd0);
        end

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            clear_drive();
            d_rst  = ($urandom_range(0, 99) == 0);
            d_if_v = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 7) != 0) a &= ~32'd3;
            d_if_a  = a;
            d_flush = ($urandom_range(0, 7) == 0);
            d_ls_v  = ($urandom_range(0, 3) != 0);
            d_ls_we = ($urandom_range(0, 1) == 1);
            d_ls_w  = 2'($urandom_range(0, 3));
            a = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) a &= ~32'd3;
            d_ls_a  = a;
            d_ls_wd = $urandom();
            step();
        end
        idle();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
